prim_filter_ctr_multi: RTL and testbench

//   Multi-channel debounce/glitch filter with a runtime-programmable stability threshold.

---
 rtl/prim_filter_ctr_multi_if.sv | 54 +++++
 rtl/prim_filter_ctr_multi.sv | 104 ++++++++++
 tb/tb_prim_filter_ctr_multi.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prim_filter_ctr_multi_if.sv
// ---------------------------------------------------------------------------
// prim_filter_ctr_multi_if
//
// Purpose:
//   Groups the data and control signals of the multi-channel debounce filter
//   into one bundle. The clock and reset are plain ports on the filter itself.
//
// Signals:
//   clr_i     synchronous clear of all channel state
//   thresh_i  stability threshold T, shared by all channels
//   enable_i  per-channel filter enable (0 = combinational bypass)
//   filter_i  raw inputs, already synchronised to the filter clock
//   filter_o  filtered outputs
//   rise_o    one-cycle pulse when a filtered value goes 0->1
//   fall_o    one-cycle pulse when a filtered value goes 1->0
//
// Modports:
//   master  the side that drives the raw inputs and controls
//   slave   the filter itself
// ---------------------------------------------------------------------------
interface prim_filter_ctr_multi_if #(
   parameter int unsigned NumChan  = 4,
   parameter int unsigned CtrWidth = 4
);

   logic                clr_i;
   logic [CtrWidth-1:0] thresh_i;
   logic [NumChan-1:0]  enable_i;
   logic [NumChan-1:0]  filter_i;
   logic [NumChan-1:0]  filter_o;
   logic [NumChan-1:0]  rise_o;
   logic [NumChan-1:0]  fall_o;

   modport master (
      output clr_i,
      output thresh_i,
      output enable_i,
      output filter_i,
      input  filter_o,
      input  rise_o,
      input  fall_o
   );

   modport slave (
      input  clr_i,
      input  thresh_i,
      input  enable_i,
      input  filter_i,
      output filter_o,
      output rise_o,
      output fall_o
   );

endinterface

// File: rtl/prim_filter_ctr_multi.sv
// ---------------------------------------------------------------------------
// prim_filter_ctr_multi
//
// Purpose:
//   Multi-channel debounce / glitch filter with a runtime-programmable
//   stability threshold. A channel forwards a new input level only after that
//   level has been sampled on T+1 consecutive clock edges (T = thresh_i), and
//   produces one-cycle rise/fall pulses when its filtered value changes.
//   Shorter pulses are suppressed entirely. T = 0 turns the filter into a
//   plain one-cycle register.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous, active-low reset
//   bus      prim_filter_ctr_multi_if slave modport carrying clr_i,
//            thresh_i, enable_i, filter_i, filter_o, rise_o, fall_o
//
// Parameters:
//   NumChan   number of independent channels (>= 1)
//   CtrWidth  width of each stability counter and of thresh_i (>= 1)
//   ResetVal  filtered state after reset or clear
// ---------------------------------------------------------------------------
module prim_filter_ctr_multi #(
   parameter int unsigned NumChan  = 4,
   parameter int unsigned CtrWidth = 4,
   parameter logic        ResetVal = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   prim_filter_ctr_multi_if.slave   bus
);

   logic [NumChan-1:0]  r_prev;
   logic [NumChan-1:0]  r_stored;
   logic [NumChan-1:0]  r_rise;
   logic [NumChan-1:0]  r_fall;
   logic [CtrWidth-1:0] r_ctr  [NumChan];

   logic [CtrWidth-1:0] w_ctrD [NumChan];
   logic [NumChan-1:0]  w_upd;

   // Next stability count per channel. A change of input restarts the count.
   // Once the count reaches the threshold it is pinned there, which also
   // pulls it down immediately if the threshold is lowered mid-count, and
   // keeps it from ever wrapping. A channel qualifies its current input
   // whenever the next count equals the threshold.
   always_comb begin
      w_upd = '0;
      for (int c = 0; c < int'(NumChan); c++) begin
         w_ctrD[c] = '0;
         if (bus.filter_i[c] != r_prev[c]) begin
            w_ctrD[c] = '0;
         end else if (r_ctr[c] >= bus.thresh_i) begin
            w_ctrD[c] = bus.thresh_i;
         end else begin
            w_ctrD[c] = r_ctr[c] + CtrWidth'(1);
         end
         w_upd[c] = (w_ctrD[c] == bus.thresh_i);
      end
   end

   // Channel state. The counters and stored values keep running while a
   // channel is bypassed, so re-enabling it shows the already-qualified level
   // at once. Event pulses are only raised for enabled channels and only when
   // the qualified level differs from the stored one. A clear drops all
   // progress but still captures the current input into r_prev, so the next
   // qualification starts counting on the following edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prev   <= {NumChan{ResetVal}};
         r_stored <= {NumChan{ResetVal}};
         r_rise   <= '0;
         r_fall   <= '0;
         for (int c = 0; c < int'(NumChan); c++) begin
            r_ctr[c] <= '0;
         end
      end else begin
         r_prev <= bus.filter_i;
         if (bus.clr_i) begin
            r_stored <= {NumChan{ResetVal}};
            r_rise   <= '0;
            r_fall   <= '0;
            for (int c = 0; c < int'(NumChan); c++) begin
               r_ctr[c] <= '0;
            end
         end else begin
            for (int c = 0; c < int'(NumChan); c++) begin
               r_ctr[c] <= w_ctrD[c];
               if (w_upd[c]) begin
                  r_stored[c] <= bus.filter_i[c];
               end
               r_rise[c] <= bus.enable_i[c] & w_upd[c] &  bus.filter_i[c] & ~r_stored[c];
               r_fall[c] <= bus.enable_i[c] & w_upd[c] & ~bus.filter_i[c] &  r_stored[c];
            end
         end
      end
   end

   // Disabled channels pass the raw input straight through with no latency.
   assign bus.filter_o = (bus.enable_i & r_stored) | (~bus.enable_i & bus.filter_i);
   assign bus.rise_o   = r_rise;
   assign bus.fall_o   = r_fall;

endmodule

// File: tb/tb_prim_filter_ctr_multi.sv
// ---------------------------------------------------------------------------
// tb_prim_filter_ctr_multi
//
// Purpose:
//   Directed, self-checking bench for prim_filter_ctr_multi with four
//   channels and a 4-bit threshold. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_prim_filter_ctr_multi;

   logic clk;
   logic rstN;
   int   testsRun;
   int   testsFailed;

   prim_filter_ctr_multi_if #(.NumChan(4), .CtrWidth(4)) bus ();

   prim_filter_ctr_multi #(
      .NumChan (4),
      .CtrWidth(4),
      .ResetVal(1'b0)
   ) dut (
      .clk_i (clk),
      .rst_ni(rstN),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive every DUT input in one go.
   task automatic applyStimulus(input logic [3:0] filt, input logic [3:0] en,
                                input logic [3:0] thr, input logic clr);
      bus.filter_i = filt;
      bus.enable_i = en;
      bus.thresh_i = thr;
      bus.clr_i    = clr;
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   logic [3:0] vecIn   [4];
   logic [3:0] vecOld  [4];
   logic [3:0] vecRise [4];
   logic [3:0] vecFall [4];
   logic [3:0] togVal;

   initial begin
      testsRun    = 0;
      testsFailed = 0;

      // Reset state
      rstN = 1'b0;
      applyStimulus(4'b0000, 4'b1111, 4'd3, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_filter", bus.filter_o, 4'b0000);
      checkOutput("rst_rise",   bus.rise_o,   4'b0000);
      checkOutput("rst_fall",   bus.fall_o,   4'b0000);
      #2 rstN = 1'b1;
      repeat (5) tick();
      checkOutput("idle_filter", bus.filter_o, 4'b0000);

      // Step on ch0 with T=3: visible after the 4th edge, single rise pulse
      applyStimulus(4'b0001, 4'b1111, 4'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("step_hold_filter", bus.filter_o, 4'b0000);
         checkOutput("step_hold_rise",   bus.rise_o,   4'b0000);
      end
      tick();
      checkOutput("step_filter", bus.filter_o, 4'b0001);
      checkOutput("step_rise",   bus.rise_o,   4'b0001);
      checkOutput("step_fall",   bus.fall_o,   4'b0000);
      tick();
      checkOutput("step_rise_end", bus.rise_o,   4'b0000);
      checkOutput("step_keep",     bus.filter_o, 4'b0001);

      // Three-cycle glitch on ch1 is suppressed
      applyStimulus(4'b0011, 4'b1111, 4'd3, 1'b0);
      repeat (3) begin
         tick();
         checkOutput("glitch_filter", bus.filter_o, 4'b0001);
         checkOutput("glitch_events", {bus.rise_o, bus.fall_o}, 8'h00);
      end
      applyStimulus(4'b0001, 4'b1111, 4'd3, 1'b0);
      repeat (5) begin
         tick();
         checkOutput("glitch_after", {bus.filter_o, bus.rise_o, bus.fall_o}, 12'h100);
      end

      // T=0: one-cycle registered pass-through with edge pulses
      applyStimulus(4'b0001, 4'b1111, 4'd0, 1'b0);
      tick();
      checkOutput("t0_settle", {bus.filter_o, bus.rise_o, bus.fall_o}, 12'h100);
      vecIn[0] = 4'b1010; vecOld[0] = 4'b0001; vecRise[0] = 4'b1010; vecFall[0] = 4'b0001;
      vecIn[1] = 4'b0101; vecOld[1] = 4'b1010; vecRise[1] = 4'b0101; vecFall[1] = 4'b1010;
      vecIn[2] = 4'b0101; vecOld[2] = 4'b0101; vecRise[2] = 4'b0000; vecFall[2] = 4'b0000;
      vecIn[3] = 4'b0000; vecOld[3] = 4'b0101; vecRise[3] = 4'b0000; vecFall[3] = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecIn[i], 4'b1111, 4'd0, 1'b0);
         #1;
         checkOutput("t0_before_edge", bus.filter_o, vecOld[i]);
         tick();
         checkOutput("t0_filter", bus.filter_o, vecIn[i]);
         checkOutput("t0_rise",   bus.rise_o,   vecRise[i]);
         checkOutput("t0_fall",   bus.fall_o,   vecFall[i]);
      end

      // T=7 mid-count on ch2, then lowered to 2: clamp qualifies next edge
      applyStimulus(4'b0000, 4'b1111, 4'd7, 1'b0);
      repeat (10) tick();
      checkOutput("t7_idle", bus.filter_o, 4'b0000);
      applyStimulus(4'b0100, 4'b1111, 4'd7, 1'b0);
      repeat (4) tick();
      checkOutput("t7_counting", bus.filter_o, 4'b0000);
      checkOutput("t7_no_rise",  bus.rise_o,   4'b0000);
      applyStimulus(4'b0100, 4'b1111, 4'd2, 1'b0);
      tick();
      checkOutput("clamp_filter", bus.filter_o, 4'b0100);
      checkOutput("clamp_rise",   bus.rise_o,   4'b0100);
      tick();
      checkOutput("clamp_rise_end", bus.rise_o, 4'b0000);

      // T=15 (max): 16 edges to qualify, then long hold without wrap effects
      applyStimulus(4'b0000, 4'b1111, 4'd15, 1'b0);
      repeat (15) tick();
      checkOutput("tmax_hold", bus.filter_o, 4'b0100);
      tick();
      checkOutput("tmax_filter", bus.filter_o, 4'b0000);
      checkOutput("tmax_fall",   bus.fall_o,   4'b0100);
      repeat (24) begin
         tick();
         checkOutput("tmax_steady", {bus.filter_o, bus.rise_o, bus.fall_o}, 12'h000);
      end

      // Ch3 bypassed: combinational tracking, no pulses; re-enable shows stored value
      applyStimulus(4'b0000, 4'b0111, 4'd3, 1'b0);
      tick();
      for (int i = 0; i < 6; i++) begin
         togVal = (i % 2 == 1) ? 4'b1000 : 4'b0000;
         applyStimulus(togVal, 4'b0111, 4'd3, 1'b0);
         #1;
         checkOutput("bypass_comb", bus.filter_o, togVal);
         tick();
         checkOutput("bypass_events", {bus.rise_o, bus.fall_o}, 8'h00);
      end
      repeat (5) begin
         tick();
         checkOutput("bypass_hold_events", {bus.rise_o, bus.fall_o}, 8'h00);
      end
      applyStimulus(4'b1000, 4'b1111, 4'd3, 1'b0);
      #1;
      checkOutput("reenable_filter", bus.filter_o, 4'b1000);
      tick();
      checkOutput("reenable_events", {bus.rise_o, bus.fall_o}, 8'h00);

      // Clear while ch0 is two edges into qualification
      applyStimulus(4'b0010, 4'b1111, 4'd3, 1'b0);
      repeat (5) tick();
      checkOutput("pre_clr", bus.filter_o, 4'b0010);
      applyStimulus(4'b0011, 4'b1111, 4'd3, 1'b0);
      repeat (2) tick();
      checkOutput("pre_clr_count", bus.filter_o, 4'b0010);
      applyStimulus(4'b0011, 4'b1111, 4'd3, 1'b1);
      tick();
      checkOutput("clr_filter", bus.filter_o, 4'b0000);
      checkOutput("clr_events", {bus.rise_o, bus.fall_o}, 8'h00);
      applyStimulus(4'b0011, 4'b1111, 4'd3, 1'b0);
      repeat (2) tick();
      checkOutput("post_clr_hold", bus.filter_o, 4'b0000);
      tick();
      checkOutput("post_clr_filter", bus.filter_o, 4'b0011);
      checkOutput("post_clr_rise",   bus.rise_o,   4'b0011);
      checkOutput("post_clr_fall",   bus.fall_o,   4'b0000);

      // Asynchronous reset while ch2 is mid-count
      applyStimulus(4'b0111, 4'b1111, 4'd3, 1'b0);
      repeat (2) tick();
      checkOutput("pre_arst", bus.filter_o, 4'b0011);
      #1 rstN = 1'b0;
      #1;
      checkOutput("arst_outputs", {bus.filter_o, bus.rise_o, bus.fall_o}, 12'h000);
      @(negedge clk);
      rstN = 1'b1;
      repeat (3) tick();
      checkOutput("post_arst_hold", bus.filter_o, 4'b0000);
      tick();
      checkOutput("post_arst_filter", bus.filter_o, 4'b0111);
      checkOutput("post_arst_rise",   bus.rise_o,   4'b0111);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
